// File: rtl/expr_drv_pkg.sv
// Shared constants and types for the expression-DUT vector driver and its MISR.
package expr_drv_pkg;

  localparam int OP_W   = 60;
  localparam int Y_W    = 90;
  localparam int SIG_W  = 32;
  localparam int LFSR_W = 64;

  // Operand field widths and LSB offsets inside op_bus, a0..a5 then b0..b5.
  localparam int A_W   [0:5] = '{4, 5, 6, 4, 5, 6};
  localparam int B_W   [0:5] = '{4, 5, 6, 4, 5, 6};
  localparam int A_LSB [0:5] = '{56, 51, 45, 41, 36, 30};
  localparam int B_LSB [0:5] = '{26, 21, 15, 11, 6, 0};

  localparam logic [SIG_W-1:0]  MISR_POLY = 32'h04C1_1DB7;
  localparam logic [SIG_W-1:0]  MISR_INIT = 32'hFFFF_FFFF;
  // Right-shifting Galois form of taps 64,63,61,60.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } st_e;

endpackage

// File: rtl/expr_misr32.sv
// 32-bit MISR compressing 90-bit expression results: three 32-bit chunks are XOR-folded per step.
module expr_misr32
  import expr_drv_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic [Y_W-1:0]   i_data,
  output logic [SIG_W-1:0] o_sig
);

  logic [3*SIG_W-1:0] w_ext;
  logic [SIG_W-1:0]   w_fold;
  logic [SIG_W-1:0]   w_next;
  logic [SIG_W-1:0]   r_sig;

  assign w_ext  = {{(3*SIG_W-Y_W){1'b0}}, i_data};
  assign w_fold = w_ext[3*SIG_W-1:2*SIG_W] ^ w_ext[2*SIG_W-1:SIG_W] ^ w_ext[SIG_W-1:0];
  assign w_next = {r_sig[SIG_W-2:0], 1'b0} ^ (r_sig[SIG_W-1] ? MISR_POLY : '0) ^ w_fold;

  always_ff @(posedge clk) begin
    if (rst || i_clear) r_sig <= MISR_INIT;
    else if (i_en)      r_sig <= w_next;
  end

  assign o_sig = r_sig;

endmodule

// File: rtl/expr_vector_driver.sv
// LFSR vector source and MISR result sink for an expression DUT, with outstanding-vector limit.
// Optional EXPR_DRV_GOLDEN_CHECK_EN adds golden_sig and a registered pass flag.
module expr_vector_driver
  import expr_drv_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int MAX_OUT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_vectors,
  input  logic [LFSR_W-1:0] seed,
`ifdef EXPR_DRV_GOLDEN_CHECK_EN
  input  logic [SIG_W-1:0]  golden_sig,
`endif
  output logic              op_valid,
  input  logic              op_ready,
  output logic [OP_W-1:0]   op_bus,
  input  logic              res_valid,
  input  logic [Y_W-1:0]    y_in,
  output logic              busy,
  output logic              done,
  output logic [SIG_W-1:0]  signature,
  output logic              proto_err,
  output logic              pass
);

  localparam int OUT_W = 4;

  st_e               r_state, w_next;
  logic [LFSR_W-1:0] r_lfsr, w_lfsr_nxt;
  logic [CNT_W-1:0]  r_nv, r_sent, r_recv;
  logic [OUT_W-1:0]  r_out;
  logic              r_perr;
  logic              w_start_acc, w_op_valid, w_hs, w_rx, w_perr;

  assign w_start_acc = start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_op_valid  = (r_state == ST_RUN) && (r_sent < r_nv) && (r_out < OUT_W'(MAX_OUT));
  assign w_hs        = w_op_valid && op_ready;
  // No ready on the result side: anything arriving with nothing outstanding is a protocol error.
  assign w_rx        = res_valid && (r_out != '0) && (r_state == ST_RUN || r_state == ST_DRAIN);
  assign w_perr      = res_valid && (r_out == '0);
  assign w_lfsr_nxt  = r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_TAPS) : (r_lfsr >> 1);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (start) w_next = ST_LOAD;
      ST_LOAD:          w_next = ST_RUN;
      ST_RUN:           if (r_sent == r_nv) w_next = ST_DRAIN;
      ST_DRAIN:         if (r_recv == r_nv) w_next = ST_DONE;
      default:          w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_lfsr  <= 64'h1;
      r_nv    <= '0;
      r_sent  <= '0;
      r_recv  <= '0;
      r_out   <= '0;
      r_perr  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start_acc) begin
        r_lfsr <= (seed == '0) ? 64'h1 : seed;
        r_nv   <= num_vectors;
        r_sent <= '0;
        r_recv <= '0;
        r_out  <= '0;
      end else begin
        if (w_hs) begin
          r_lfsr <= w_lfsr_nxt;
          r_sent <= r_sent + 1'b1;
        end
        if (w_rx) r_recv <= r_recv + 1'b1;
        case ({w_hs, w_rx})
          2'b10:   r_out <= r_out + 1'b1;
          2'b01:   r_out <= r_out - 1'b1;
          default: r_out <= r_out;
        endcase
      end
      if (w_perr)           r_perr <= 1'b1;
      else if (w_start_acc) r_perr <= 1'b0;
    end
  end

  expr_misr32 u_misr (
    .clk     (clk),
    .rst     (rst),
    .i_clear (r_state == ST_LOAD),
    .i_en    (w_rx),
    .i_data  (y_in),
    .o_sig   (signature)
  );

`ifdef EXPR_DRV_GOLDEN_CHECK_EN
  logic [SIG_W-1:0] r_gold;
  logic             r_pass;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gold <= '0;
      r_pass <= 1'b0;
    end else if (w_start_acc) begin
      r_gold <= golden_sig;
      r_pass <= 1'b0;
    end else if (r_state == ST_DRAIN && w_next == ST_DONE) begin
      r_pass <= (signature == r_gold);
    end
  end

  assign pass = r_pass;
`else
  assign pass = 1'b0;
`endif

  assign op_valid  = w_op_valid;
  assign op_bus    = r_lfsr[OP_W-1:0];
  assign busy      = (r_state == ST_LOAD) || (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign done      = (r_state == ST_DONE);
  assign proto_err = r_perr;

endmodule

// File: tb/tb_expr_vector_driver.sv
// Randomized self-checking bench for expr_vector_driver; the bench plays an in-order expression DUT.
module tb_expr_vector_driver;

  localparam logic [63:0] TAPS    = 64'hD800_0000_0000_0000;
  localparam int          MAX_OUT = 4;
`ifdef EXPR_DRV_GOLDEN_CHECK_EN
  localparam logic        PASS_EXP = 1'b1;
`else
  localparam logic        PASS_EXP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, op_ready, res_valid;
  logic [15:0] num_vectors;
  logic [63:0] seed;
  logic [89:0] y_in;
  logic        op_valid, busy, done, proto_err, pass;
  logic [59:0] op_bus;
  logic [31:0] signature;
`ifdef EXPR_DRV_GOLDEN_CHECK_EN
  logic [31:0] golden_sig;
`endif

  always #5 clk = ~clk;

  expr_vector_driver #(.CNT_W(16), .MAX_OUT(MAX_OUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_vectors (num_vectors),
    .seed        (seed),
`ifdef EXPR_DRV_GOLDEN_CHECK_EN
    .golden_sig  (golden_sig),
`endif
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_bus      (op_bus),
    .res_valid   (res_valid),
    .y_in        (y_in),
    .busy        (busy),
    .done        (done),
    .signature   (signature),
    .proto_err   (proto_err),
    .pass        (pass)
  );

  int          n_cmp = 0, n_err = 0;
  int          n_hs, n_ov, cur_nv;
  logic [63:0] m_lfsr;
  logic [31:0] cur_exp;
  logic [89:0] pend[$];
  bit          y_zero;
  logic        s_ov_pre;
  logic [59:0] s_bus_pre;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] lfsr_next(input logic [63:0] x);
    return x[0] ? ((x >> 1) ^ TAPS) : (x >> 1);
  endfunction

  // The emulated DUT answers each vector with a value derived from it, so reruns are reproducible.
  function automatic logic [89:0] mk_y(input logic [59:0] op, input bit z);
    return z ? 90'd0 : {op[29:0], op};
  endfunction

  function automatic logic [31:0] exp_sig(input logic [63:0] sd, input int nv, input bit z);
    logic [63:0] x;
    logic [95:0] y;
    logic [31:0] s;
    x = (sd == 64'd0) ? 64'd1 : sd;
    s = 32'hFFFF_FFFF;
    for (int i = 0; i < nv; i++) begin
      y = {6'd0, mk_y(x[59:0], z)};
      s = {s[30:0], 1'b0} ^ (s[31] ? 32'h04C1_1DB7 : 32'd0) ^ y[95:64] ^ y[63:32] ^ y[31:0];
      x = lfsr_next(x);
    end
    return s;
  endfunction

  task automatic set_gold(input logic [31:0] g);
`ifdef EXPR_DRV_GOLDEN_CHECK_EN
    golden_sig = g;
`else
    if (g == 32'd0) n_hs = 0;
`endif
  endtask

  task automatic pulse_start(input logic [63:0] sd, input int nv, input bit z);
    y_zero  = z;
    cur_nv  = nv;
    cur_exp = exp_sig(sd, nv, z);
    @(negedge clk);
    start       = 1'b1;
    seed        = sd;
    num_vectors = nv[15:0];
    set_gold(cur_exp);
    m_lfsr = (sd == 64'd0) ? 64'd1 : sd;
    n_hs = 0;
    n_ov = 0;
    pend.delete();
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic step(input bit rdy, input bit give);
    @(negedge clk);
    op_ready = rdy;
    if (give && pend.size() != 0) begin
      res_valid = 1'b1;
      y_in      = pend.pop_front();
    end else begin
      res_valid = 1'b0;
      y_in      = '0;
    end
    #1;
    s_ov_pre  = op_valid;
    s_bus_pre = op_bus;
    if (op_valid) n_ov++;
    if (op_valid && rdy) begin
      chk("op_bus", op_bus, m_lfsr[59:0]);
      pend.push_back(mk_y(m_lfsr[59:0], y_zero));
      m_lfsr = lfsr_next(m_lfsr);
      n_hs++;
      chk("max_outstanding", pend.size() <= MAX_OUT, 1);
    end
    @(posedge clk); #1;
    res_valid = 1'b0;
  endtask

  task automatic finish_run();
    int c;
    c = 0;
    while (!done && c < 3000) begin
      step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 50);
      c++;
    end
    chk("run_done", done, 1);
    chk("run_handshakes", n_hs, cur_nv);
    chk("run_signature", signature, cur_exp);
    chk("run_busy", busy, 0);
    chk("run_op_valid", op_valid, 0);
    chk("run_pass", pass, PASS_EXP);
  endtask

  task automatic bad_resp(input logic [31:0] sig_exp);
    @(negedge clk);
    res_valid = 1'b1;
    y_in      = {$urandom, $urandom, $urandom};
    @(posedge clk); #1;
    res_valid = 1'b0;
    chk("perr_set", proto_err, 1);
    chk("perr_sig_kept", signature, sig_exp);
  endtask

  initial begin
    int bc, c;
    logic [63:0] sd;
    rst = 1'b1; start = 1'b0; op_ready = 1'b0; res_valid = 1'b0;
    num_vectors = '0; seed = '0; y_in = '0;
    set_gold(32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_op_valid", op_valid, 0);
    chk("rst_op_bus", op_bus, 60'h1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sig", signature, 32'hFFFF_FFFF);
    chk("rst_perr", proto_err, 0);
    chk("rst_pass", pass, 0);
    rst = 1'b0;

    // Empty run: LOAD, RUN, DRAIN then DONE.
    pulse_start(64'h1234_5678_9ABC_DEF0, 0, 1'b0);
    bc = 0;
    for (int i = 0; i < 6; i++) begin
      if (busy) bc++;
      step(1'b1, 1'b0);
    end
    chk("nv0_busy_cycles", bc, 3);
    chk("nv0_no_op_valid", n_ov, 0);
    chk("nv0_done", done, 1);
    chk("nv0_sig", signature, 32'hFFFF_FFFF);

    // Zero seed, single vector answered with zero.
    pulse_start(64'd0, 1, 1'b1);
    finish_run();
    chk("seed0_sig_const", signature, 32'hFB3E_E249);
    bad_resp(32'hFB3E_E249);

    // Back-pressure: vector must hold steady, then advance once.
    sd = {$urandom, $urandom};
    pulse_start(sd, 3, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0);
      chk("hold_valid", s_ov_pre, 1);
      chk("hold_bus", s_bus_pre, sd[59:0]);
    end
    step(1'b1, 1'b0);
    chk("release_one_hs", n_hs, 1);
    step(1'b0, 1'b0);
    chk("lfsr_adv_once", s_bus_pre, lfsr_next(sd) & 64'h0FFF_FFFF_FFFF_FFFF);
    finish_run();

    // Outstanding limit with results withheld.
    pulse_start({$urandom, $urandom}, 10, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0);
    chk("limit_hs", n_hs, MAX_OUT);
    chk("limit_valid_low", s_ov_pre, 0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("limit_reassert", s_ov_pre, 1);
    finish_run();

    // Reset mid-run, stray result in IDLE, then rerun from the same seed.
    sd = {$urandom, $urandom};
    pulse_start(sd, 100, 1'b0);
    c = 0;
    while (n_hs < 5 && c < 500) begin
      step(1'b1, 1'b1);
      c++;
    end
    chk("midrun_hs", n_hs, 5);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst_op_valid", op_valid, 0);
    chk("mrst_op_bus", op_bus, 60'h1);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_sig", signature, 32'hFFFF_FFFF);
    chk("mrst_pass", pass, 0);
    bad_resp(32'hFFFF_FFFF);
    chk("idle_busy", busy, 0);
    pulse_start(sd, 100, 1'b0);
    chk("perr_cleared", proto_err, 0);
    finish_run();

    for (int k = 0; k < 4; k++) begin
      pulse_start({$urandom, $urandom}, $urandom_range(1, 40), 1'b0);
      finish_run();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
